// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone arbiter with a bus-timeout watchdog.
//   Grants the shared bus to m0 or m1 (round-robin on ties), keeps the grant
//   until the owner drops cyc, and ends any strobe that waits TIMEOUT cycles
//   without an ack by returning err to the owner.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   m0_*/m1_*           master request inputs, data/ack/err returns
//   s_*                 shared bus request outputs, slave data/ack inputs
//   owner_o             current or last grant (0 = m0)
//   busy_o              arbiter holds a grant
//   to_flag_o           sticky, set by any timeout
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic        owner_o,
    output logic        busy_o,
    output logic        to_flag_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

    logic [0:0]      state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            to_flag_q, to_flag_d;

    logic            busy;
    logic            own_cyc;
    logic            own_stb;
    logic            own_we;
    logic [3:0]      own_sel;
    logic [31:0]     own_adr;
    logic [31:0]     own_dat;
    logic            timeout_hit;
    logic            own_ack;

    // Owner request mux
    assign busy    = (state_q == BUSY);
    assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
    assign own_stb = owner_q ? m1_stb_i : m0_stb_i;
    assign own_we  = owner_q ? m1_we_i  : m0_we_i;
    assign own_sel = owner_q ? m1_sel_i : m0_sel_i;
    assign own_adr = owner_q ? m1_adr_i : m0_adr_i;
    assign own_dat = owner_q ? m1_dat_i : m0_dat_i;

    // An ack in the limit cycle wins over the timeout
    assign timeout_hit = busy & own_stb & ~s_ack_i & (cnt_q == TO_VAL);
    assign own_ack     = busy & own_stb & s_ack_i;

    // Shared bus: idle drives zeros, error cycle drops cyc/stb only
    assign s_cyc_o = busy & own_cyc & ~timeout_hit;
    assign s_stb_o = busy & own_stb & ~timeout_hit;
    assign s_we_o  = busy & own_we;
    assign s_sel_o = busy ? own_sel : 4'h0;
    assign s_adr_o = busy ? own_adr : 32'h0;
    assign s_dat_o = busy ? own_dat : 32'h0;

    // Return path: only the owner sees data and terminations
    assign m0_ack_o = own_ack & ~owner_q;
    assign m1_ack_o = own_ack &  owner_q;
    assign m0_err_o = timeout_hit & ~owner_q;
    assign m1_err_o = timeout_hit &  owner_q;
    assign m0_dat_o = (busy && !owner_q) ? s_dat_i : 32'h0;
    assign m1_dat_o = (busy &&  owner_q) ? s_dat_i : 32'h0;

    assign owner_o   = owner_q;
    assign busy_o    = busy;
    assign to_flag_o = to_flag_q;

    // Next-state: grant, release and watchdog count
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        to_flag_d = to_flag_q | timeout_hit;

        case (state_q)
            IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    state_d = BUSY;
                    // Tie goes to the master that did not win last time
                    owner_d = (m0_cyc_i && m1_cyc_i) ? ~last_q : m1_cyc_i;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else if (timeout_hit || s_ack_i || !own_stb) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            to_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            to_flag_q <= to_flag_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed vector table plus a timeout-latency sequence for
// wb_arbiter2 built with TIMEOUT=4.
module tb_wb_arbiter2;

    localparam int unsigned NV = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_ack_i;
    logic        owner_o, busy_o, to_flag_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .owner_o(owner_o), .busy_o(busy_o), .to_flag_o(to_flag_o)
    );

    // in  = {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}
    // exp = {s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err, owner, busy, to_flag}
    typedef struct packed {
        logic [5:0] in;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        logic [8:0]   got_ctl;
        logic [127:0] got_dat, exp_dat;
        logic         eb, eo;
        int           first_stb, err_cyc;
        logic         err_stb, found, m1_err_seen;

        // single read, tie after reset, alternating grants
        vecs[0]  = '{6'b000000, 9'b000000000};
        vecs[1]  = '{6'b011110, 9'b000000000};
        vecs[2]  = '{6'b011111, 9'b111000010};
        vecs[3]  = '{6'b000110, 9'b000000010};
        vecs[4]  = '{6'b011110, 9'b000000000};
        vecs[5]  = '{6'b011111, 9'b110100110};
        vecs[6]  = '{6'b011000, 9'b000000110};
        vecs[7]  = '{6'b011110, 9'b000000100};
        vecs[8]  = '{6'b011111, 9'b111000010};
        vecs[9]  = '{6'b000110, 9'b000000010};
        vecs[10] = '{6'b000110, 9'b000000000};
        // m1 owns; m0 held off; ack on the 4th wait cycle
        vecs[11] = '{6'b011110, 9'b110000110};
        vecs[12] = '{6'b011110, 9'b110000110};
        vecs[13] = '{6'b011110, 9'b110000110};
        vecs[14] = '{6'b011110, 9'b110000110};
        vecs[15] = '{6'b011111, 9'b110100110};
        vecs[16] = '{6'b011100, 9'b100000110};
        // no ack: err 4 cycles after the strobe rises
        vecs[17] = '{6'b011110, 9'b110000110};
        vecs[18] = '{6'b011110, 9'b110000110};
        vecs[19] = '{6'b011110, 9'b110000110};
        vecs[20] = '{6'b011110, 9'b110000110};
        vecs[21] = '{6'b011110, 9'b000001110};
        vecs[22] = '{6'b011100, 9'b100000111};
        vecs[23] = '{6'b011000, 9'b000000111};
        // m0 grabs the bus, reset mid-access, then m1-only grant
        vecs[24] = '{6'b011000, 9'b000000101};
        vecs[25] = '{6'b011000, 9'b110000011};
        vecs[26] = '{6'b111000, 9'b110000011};
        vecs[27] = '{6'b000110, 9'b000000000};
        vecs[28] = '{6'b000110, 9'b110000110};
        vecs[29] = '{6'b000111, 9'b110100110};
        vecs[30] = '{6'b000000, 9'b000000110};
        vecs[31] = '{6'b000000, 9'b000000100};

        m0_we_i = 1'b0; m0_sel_i = 4'hF; m0_adr_i = 32'h1000_0000; m0_dat_i = 32'h1111_1111;
        m1_we_i = 1'b1; m1_sel_i = 4'h3; m1_adr_i = 32'h0000_0000; m1_dat_i = 32'h2222_2222;
        s_dat_i = 32'h0000_000A;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < int'(NV); i++) begin
            @(negedge clk);
            {rst, m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i} = vecs[i].in;
            #2;
            got_ctl = {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
                       owner_o, busy_o, to_flag_o};
            check($sformatf("ctl[%0d]", i), 128'(got_ctl), 128'(vecs[i].exp));
            eb = vecs[i].exp[1];
            eo = vecs[i].exp[2];
            exp_dat = {(eb && !eo) ? 32'h0000_000A : 32'h0,
                       (eb &&  eo) ? 32'h0000_000A : 32'h0,
                       eb ? (eo ? m1_adr_i : m0_adr_i) : 32'h0,
                       eb ? (eo ? m1_dat_i : m0_dat_i) : 32'h0};
            exp_dat[127:96] = exp_dat[127:96] |
                32'({eb & (eo ? m1_we_i : m0_we_i), eb ? (eo ? m1_sel_i : m0_sel_i) : 4'h0}) << 0;
            got_dat = {m0_dat_o, m1_dat_o, s_adr_o, s_dat_o};
            got_dat[127:96] = got_dat[127:96] | 32'({s_we_o, s_sel_o});
            check($sformatf("data[%0d]", i), got_dat, exp_dat);
        end

        // m0 never acked: measure strobe-to-err latency
        first_stb = -1; err_cyc = -1; err_stb = 1'b1; found = 1'b0; m1_err_seen = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            rst = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
            m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
            #2;
            if (s_stb_o && first_stb < 0) first_stb = c;
            if (m1_err_o) m1_err_seen = 1'b1;
            if (m0_err_o) begin
                err_cyc = c;
                err_stb = s_stb_o;
                found   = 1'b1;
            end
        end
        check("err_seen", 128'(found), 128'(1'b1));
        check("err_latency", 128'(err_cyc - first_stb), 128'(4));
        check("err_stb_low", 128'(err_stb), 128'(1'b0));
        check("no_m1_err", 128'(m1_err_seen), 128'(1'b0));
        @(negedge clk);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #2;
        check("to_flag_after", 128'(to_flag_o), 128'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master Wishbone arbiter with a bus-timeout watchdog. It sits between the masters and the memory-mapped peripheral bus: the `wb_oisc` core on port m0, and a second master such as a UART boot loader or debug/DMA engine on port m1. It drives the single shared bus that feeds the one-hot address decode. Only the owning master sees acknowledges. A transaction that a slave never acknowledges is terminated with an error, so an unmapped or hung address cannot stall the system.

## Interface
Parameters:
- `TIMEOUT`, 255: wait cycles without ack, with strobe high, before the arbiter aborts the access. Legal range 1..255.
- `TO_W`, 8: counter width. `2**TO_W` must be greater than `TIMEOUT`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 request.
- `m0_sel_i`  in  4  master 0 byte select.
- `m0_adr_i`, `m0_dat_i`  in  32 each  master 0 address and write data.
- `m0_dat_o`  out  32  read data to master 0.
- `m0_ack_o`, `m0_err_o`  out  1 each  master 0 termination.
- `m1_*`: identical set for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  shared bus request.
- `s_sel_o`  out  4  shared byte select.
- `s_adr_o`, `s_dat_o`  out  32 each  shared address and write data.
- `s_dat_i`  in  32  muxed slave read data.
- `s_ack_i`  in  1  OR of all slave acks.
- `owner_o`  out  1  current or last grant; 0 = m0.
- `busy_o`  out  1  arbiter in BUSY state.
- `to_flag_o`  out  1  sticky; set on any timeout.

## Operation
- Registers:
  - `state` ∈ {IDLE, BUSY}.
  - `owner`.
  - `last`: last master granted.
  - `cnt[TO_W-1:0]`.
  - `to_flag`.
- IDLE:
  - Shared bus outputs are all 0.
  - If only one `mX_cyc_i` is high, grant X.
  - If both are high, grant `!last` (round-robin).
  - On a grant: `owner` ← X, `state` ← BUSY, `cnt` ← 0.
- BUSY, bus forwarding:
  - `s_cyc_o`/`s_stb_o`/`s_we_o`/`s_sel_o`/`s_adr_o`/`s_dat_o` mirror the owner's inputs combinationally.
  - `s_cyc_o` and `s_stb_o` are forced to 0 in an error cycle.
- BUSY, return path:
  - `m<owner>_ack_o = s_ack_i & m<owner>_stb_i`.
  - The non-owner's ack and err are always 0.
  - `m<owner>_dat_o = s_dat_i`; the non-owner's data output is 0.
- Watchdog, counting:
  - In each BUSY cycle with `s_stb_o` high and `s_ack_i` low, `cnt` increments.
  - On `s_ack_i`, `cnt` clears.
  - While `m<owner>_stb_i` is low, `cnt` holds at 0.
- Watchdog, error cycle:
  - When `cnt == TIMEOUT` and `s_ack_i` is low, `m<owner>_err_o` goes to 1 for that cycle.
  - `s_stb_o` and `s_cyc_o` are forced to 0 in the same cycle.
  - `cnt` ← 0 and `to_flag` ← 1.
  - The master treats err like ack and ends the access.
- Release:
  - When the owner drops `m<owner>_cyc_i` in BUSY, next `state` = IDLE and `last` ← owner.
  - Bus outputs are 0 in the cycle after release.
  - There is always at least one IDLE cycle between grants.
- The owner may hold cyc across multiple strobes (burst or lock). The grant persists, with no preemption.

## Timing
- Reset values:
  - Internal: state IDLE, `owner` 0, `last` 1 (so m0 wins the first tie), `cnt` 0, `to_flag` 0.
  - Outputs: every output 0, including `owner_o`, `busy_o` and `to_flag_o`.
- Arbitration latency is 1 cycle. If cyc rises in cycle n, `s_cyc_o` is asserted in cycle n+1.
- Ack and read data pass through with 0 cycles of added latency.
- With TIMEOUT=T, a never-acked strobe first seen on the bus in cycle k gets err in cycle k+T.
- `s_ack_i` in the same cycle that `cnt == TIMEOUT`: ack wins, there is no err, and `cnt` clears.
- `s_ack_i` while IDLE is ignored and not forwarded.
- A non-owner request while BUSY is held off. It is granted after the release IDLE cycle, with fairness preserved by `last`.
- `rst` mid-transaction takes effect at the next edge. All outputs are 0 the following cycle, and no ack or err is delivered for the aborted access.

## Test plan
- Single m0 read: m0 cyc/stb at adr 0x10000000, slave acks 2 cycles after `s_stb_o` with 0x0000000A → `m0_ack_o` for 1 cycle, `m0_dat_o`=0x0000000A, `m1_ack_o` stays 0, `owner_o`=0.
- Tie after reset: m0 and m1 both request in the same cycle → m0 is granted first. After m0 releases, m1 is granted following exactly 1 IDLE cycle. On the next tie, m0 wins again.
- Back-to-back fairness: m0 requests continuously and m1 requests continuously → grants alternate 0,1,0,1, each separated by 1 IDLE cycle.
- Timeout with TIMEOUT=4: m1 writes to adr 0x00000000, no ack → `m1_err_o` high exactly 4 cycles after `s_stb_o` first rises. `s_stb_o` is 0 in that cycle and `to_flag_o` is 1 afterwards.
- Ack at boundary: TIMEOUT=4, ack on the 4th wait cycle → `m1_ack_o`=1, `m1_err_o`=0, `to_flag_o` unchanged.
- Reset mid-BUSY: assert `rst` while m0 holds the bus with no ack → next cycle all outputs are 0 and the state is IDLE. After `rst` drops, an m1-only request is granted within 1 cycle.
